// File: rtl/cnn_pkg.sv
// Shared types and sizes for the CNN feature-map datapath.
// Pooled columns are ROWS signed elements, stored and replayed without modification.
package cnn_pkg;

  localparam int DATA_W    = 16;
  localparam int POOL_ROWS = 12;
  localparam int POOL_COLS = 12;
  localparam int IDX_W     = 4;

  typedef logic [POOL_ROWS-1:0][DATA_W-1:0] column_t;

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    FULL,
    DRAINING
  } bank_state_t;

endpackage

// File: rtl/map_bank.sv
// One feature-map bank: COLS registered columns, a synchronous write port and a
// combinational read port. Storage is data only and carries no reset.
module map_bank #(
  parameter int ROWS   = cnn_pkg::POOL_ROWS,
  parameter int COLS   = cnn_pkg::POOL_COLS,
  parameter int DATA_W = cnn_pkg::DATA_W
) (
  input  logic                               clk,
  input  logic                               we,
  input  logic [cnn_pkg::IDX_W-1:0]          wr_col,
  input  logic [ROWS-1:0][DATA_W-1:0]        column,
  input  logic [cnn_pkg::IDX_W-1:0]          rd_col,
  output logic [ROWS-1:0][DATA_W-1:0]        rd_column
);
  import cnn_pkg::*;

  localparam logic [IDX_W-1:0] LAST_COL = IDX_W'(COLS - 1);

  logic [ROWS-1:0][DATA_W-1:0] mem [COLS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_col] <= column;
    end
  end

  // Out-of-range addresses occur when the read side looks one past the last column.
  assign rd_column = (rd_col <= LAST_COL) ? mem[rd_col] : '0;

endmodule

// File: rtl/pooled_map_buffer.sv
// Collects pooled columns into ping-pong 12x12 feature maps and replays each
// completed map column by column over a valid/ready stream; drops and flags on overflow.
module pooled_map_buffer #(
  parameter int ROWS   = cnn_pkg::POOL_ROWS,
  parameter int COLS   = cnn_pkg::POOL_COLS,
  parameter int DATA_W = cnn_pkg::DATA_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [ROWS-1:0][DATA_W-1:0] in_column,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ROWS-1:0][DATA_W-1:0] out_column,
  output logic [3:0]                  out_col_idx,
  output logic                        out_last,
  output logic                        overflow,
  output logic                        busy
);
  import cnn_pkg::*;

  localparam logic [0:0] RD_IDLE   = 1'b0;
  localparam logic [0:0] RD_STREAM = 1'b1;
  localparam logic [3:0] LAST_COL  = 4'(COLS - 1);

  bank_state_t                 bank_state [2];
  bank_state_t                 bank_next  [2];
  logic [0:0]                  rd_state;
  logic                        wr_bank;
  logic                        rd_bank;
  logic                        other_bank;
  logic [3:0]                  wr_col;
  logic                        wr_accept;
  logic                        wr_done;
  logic                        handshake;
  logic                        finish;
  logic                        other_ready;
  logic                        start_idle;
  logic                        rd_sel_bank;
  logic [3:0]                  rd_sel_col;
  logic [ROWS-1:0][DATA_W-1:0] bank_column [2];
  logic [ROWS-1:0][DATA_W-1:0] rd_data;

  assign other_bank = ~rd_bank;
  assign wr_accept  = in_valid &&
                      ((bank_state[wr_bank] == EMPTY) || (bank_state[wr_bank] == FILLING));
  assign wr_done    = wr_accept && (wr_col == LAST_COL);
  assign handshake  = out_valid && out_ready;
  assign finish     = handshake && out_last;
  assign start_idle = (rd_state == RD_IDLE) && (bank_state[rd_bank] == FULL);
  // A map completing on the same edge as the final beat hands over without a bubble.
  assign other_ready = (bank_state[other_bank] == FULL) ||
                       (wr_done && (wr_bank == other_bank));

  always_comb begin
    rd_sel_bank = rd_bank;
    rd_sel_col  = out_col_idx + 4'd1;
    if (start_idle) begin
      rd_sel_col = '0;
    end else if (finish) begin
      rd_sel_bank = other_bank;
      rd_sel_col  = '0;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    map_bank #(
      .ROWS  (ROWS),
      .COLS  (COLS),
      .DATA_W(DATA_W)
    ) u_bank (
      .clk      (clk),
      .we       (wr_accept && (wr_bank == 1'(b))),
      .wr_col   (wr_col),
      .column   (in_column),
      .rd_col   (rd_sel_col),
      .rd_column(bank_column[b])
    );
  end

  assign rd_data = bank_column[rd_sel_bank];

  // Read-side transitions are applied after the write so a handover claims a just-filled bank.
  always_comb begin
    bank_next[0] = bank_state[0];
    bank_next[1] = bank_state[1];
    if (wr_accept) begin
      bank_next[wr_bank] = wr_done ? FULL : FILLING;
    end
    if (start_idle) begin
      bank_next[rd_bank] = DRAINING;
    end
    if (finish) begin
      bank_next[rd_bank] = EMPTY;
      if (other_ready) begin
        bank_next[other_bank] = DRAINING;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank_state[0] <= EMPTY;
      bank_state[1] <= EMPTY;
      wr_bank       <= 1'b0;
      wr_col        <= '0;
      rd_bank       <= 1'b0;
      rd_state      <= RD_IDLE;
      overflow      <= 1'b0;
      out_column    <= '0;
      out_col_idx   <= '0;
      out_last      <= 1'b0;
    end else begin
      bank_state[0] <= bank_next[0];
      bank_state[1] <= bank_next[1];

      if (wr_accept) begin
        wr_col <= wr_done ? 4'd0 : wr_col + 4'd1;
        if (wr_done) begin
          wr_bank <= ~wr_bank;
        end
      end else if (in_valid) begin
        overflow <= 1'b1;
      end

      case (rd_state)
        RD_IDLE: begin
          if (start_idle) begin
            rd_state    <= RD_STREAM;
            out_column  <= rd_data;
            out_col_idx <= '0;
            out_last    <= (LAST_COL == 4'd0);
          end
        end
        default: begin
          if (handshake) begin
            if (out_last) begin
              rd_bank <= other_bank;
              if (other_ready) begin
                out_column  <= rd_data;
                out_col_idx <= '0;
                out_last    <= (LAST_COL == 4'd0);
              end else begin
                rd_state <= RD_IDLE;
                out_last <= 1'b0;
              end
            end else begin
              out_column  <= rd_data;
              out_col_idx <= rd_sel_col;
              out_last    <= (rd_sel_col == LAST_COL);
            end
          end
        end
      endcase
    end
  end

  assign out_valid = (rd_state == RD_STREAM);
  assign busy      = (bank_state[0] != EMPTY) || (bank_state[1] != EMPTY);

endmodule

// File: tb/tb_pooled_map_buffer.sv
// Bench for pooled_map_buffer: directed maps checked every cycle against a
// map-level model (two map slots, FIFO replay) plus hand-computed literals.
module tb_pooled_map_buffer;
  localparam int ROWS   = 12;
  localparam int COLS   = 12;
  localparam int DATA_W = 16;

  typedef logic [ROWS-1:0][DATA_W-1:0] col_t;
  typedef struct {
    logic [191:0] col;
    logic [3:0]   idx;
    logic         last;
    int           cedge;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       out_ready;
  logic       out_valid;
  logic       out_last;
  logic       overflow;
  logic       busy;
  col_t       in_column;
  col_t       out_column;
  logic [3:0] out_col_idx;

  int checks   = 0;
  int failures = 0;

  beat_t        q[$];
  logic [191:0] cur_map[$];
  int           maps_filled = 0;
  int           maps_read   = 0;
  int           mcyc        = 0;
  logic         m_valid     = 1'b0;
  logic         m_ovf       = 1'b0;

  int           hs_cyc[$];
  logic [191:0] hs_col[$];
  int           last_cnt = 0;
  int           ncyc     = 0;

  pooled_map_buffer dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_column  (in_column),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_column (out_column),
    .out_col_idx(out_col_idx),
    .out_last   (out_last),
    .overflow   (overflow),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Model: a map may start filling only once the map two slots earlier has fully
  // replayed; maps replay in arrival order, first beat one edge after completion,
  // or on the final-beat edge of the previous map if already complete by then.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      cur_map.delete();
      maps_filled = 0;
      maps_read   = 0;
      m_valid     = 1'b0;
      m_ovf       = 1'b0;
    end else begin : model_step
      bit    hs;
      beat_t b;
      beat_t nb;
      mcyc++;
      hs = m_valid && out_ready;
      if (in_valid) begin
        if (maps_filled < maps_read + 2) begin
          cur_map.push_back(in_column);
          if (cur_map.size() == COLS) begin
            for (int c = 0; c < COLS; c++) begin
              nb.col   = cur_map[c];
              nb.idx   = 4'(c);
              nb.last  = (c == COLS - 1);
              nb.cedge = mcyc;
              q.push_back(nb);
            end
            cur_map.delete();
            maps_filled++;
          end
        end else begin
          m_ovf = 1'b1;
        end
      end
      if (hs) begin
        b = q.pop_front();
        if (b.last) begin
          maps_read++;
          m_valid = (q.size() > 0);
        end
      end else if (!m_valid && q.size() > 0 && q[0].cedge < mcyc) begin
        m_valid = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    ncyc++;
    if (!rst) begin
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_column", out_column, '0);
      chk("rst_out_col_idx", out_col_idx, 4'd0);
      chk("rst_out_last", out_last, 1'b0);
      chk("rst_overflow", overflow, 1'b0);
      chk("rst_busy", busy, 1'b0);
    end else begin
      chk("out_valid", out_valid, m_valid);
      chk("overflow", overflow, m_ovf);
      chk("busy", busy, (cur_map.size() > 0) || (q.size() > 0));
      if (m_valid) begin
        chk("out_column", out_column, q[0].col);
        chk("out_col_idx", out_col_idx, q[0].idx);
        chk("out_last", out_last, q[0].last);
      end
      if (out_valid && out_ready) begin
        hs_cyc.push_back(ncyc);
        hs_col.push_back(out_column);
        if (out_last) last_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic col_t mk(input int base, input int k);
    col_t c;
    for (int r = 0; r < ROWS; r++) c[r] = 16'(base + k * 16 + r);
    return c;
  endfunction

  task automatic send(input int base, input int k);
    in_valid  = 1'b1;
    in_column = mk(base, k);
    tick();
    in_valid  = 1'b0;
  endtask

  function automatic logic [15:0] elem(input int i, input int r);
    logic [191:0] t;
    t = hs_col[i];
    return t[r*16 +: 16];
  endfunction

  task automatic wait_idle(input string name);
    int n = 0;
    while ((out_valid || busy) && n < 300) begin
      tick();
      n++;
    end
    chk(name, (n < 300), 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    int lc0;
    int k;
    int n;
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_column = '0;
    tick();
    tick();
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_overflow", overflow, 1'b0);
    chk("reset_idx", out_col_idx, 4'd0);
    rst = 1'b1;
    tick();

    // single map
    out_ready = 1'b1;
    b0 = hs_cyc.size(); lc0 = last_cnt;
    for (int i = 0; i < 12; i++) send(0, i);
    chk("t1_no_valid_at_last_write", out_valid, 1'b0);
    tick();
    chk("t1_valid_one_cycle_later", out_valid, 1'b1);
    chk("t1_first_idx", out_col_idx, 4'd0);
    chk("t1_first_elem5", out_column[5], 16'd5);
    wait_idle("t1_idle");
    chk("t1_beats", hs_cyc.size() - b0, 12);
    chk("t1_lasts", last_cnt - lc0, 1);
    chk("t1_last_elem11", elem(b0 + 11, 11), 16'd187);
    chk("t1_overflow", overflow, 1'b0);

    // backpressure 1,0,0,1
    b0 = hs_cyc.size(); lc0 = last_cnt;
    for (int i = 0; i < 60; i++) begin
      in_valid  = (i < 12);
      in_column = mk(16'h1000, i);
      out_ready = ((i % 4) == 0) || ((i % 4) == 3);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_idle("t2_idle");
    chk("t2_beats", hs_cyc.size() - b0, 12);
    chk("t2_lasts", last_cnt - lc0, 1);
    chk("t2_beat7_elem0", elem(b0 + 7, 0), 16'h1070);

    // ping-pong, no bubble
    b0 = hs_cyc.size(); lc0 = last_cnt;
    for (int i = 0; i < 24; i++) send(16'h6000, i);
    wait_idle("t3_idle");
    chk("t3_beats", hs_cyc.size() - b0, 24);
    chk("t3_contiguous", hs_cyc[b0 + 23] - hs_cyc[b0], 23);
    chk("t3_lasts", last_cnt - lc0, 2);
    chk("t3_map2_first", elem(b0 + 12, 0), 16'h60C0);

    // overflow
    out_ready = 1'b0;
    b0 = hs_cyc.size();
    for (int i = 0; i < 36; i++) begin
      send(16'h2000, i);
      if (i == 23) chk("t4_overflow_before", overflow, 1'b0);
      if (i == 24) chk("t4_overflow_set", overflow, 1'b1);
    end
    out_ready = 1'b1;
    wait_idle("t4_idle");
    chk("t4_beats", hs_cyc.size() - b0, 24);
    chk("t4_map2_first", elem(b0 + 12, 0), 16'h20C0);
    chk("t4_final_beat", elem(b0 + 23, 0), 16'h2170);
    chk("t4_overflow_sticky", overflow, 1'b1);

    // async reset mid-stream
    b0 = hs_cyc.size();
    for (int i = 0; i < 12; i++) send(16'h3000, i);
    n = 0;
    while (hs_cyc.size() < b0 + 5 && n < 50) begin
      tick();
      n++;
    end
    chk("t5_reach_beat5", (n < 50), 1'b1);
    chk("t5_mid_valid", out_valid, 1'b1);
    #1 rst = 1'b0;
    #1;
    chk("t5_async_valid", out_valid, 1'b0);
    chk("t5_async_busy", busy, 1'b0);
    chk("t5_async_overflow", overflow, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    b0 = hs_cyc.size(); lc0 = last_cnt;
    for (int i = 0; i < 12; i++) send(16'h4000, i);
    wait_idle("t5_idle");
    chk("t5_beats", hs_cyc.size() - b0, 12);
    chk("t5_first_elem3", elem(b0, 3), 16'h4003);
    chk("t5_lasts", last_cnt - lc0, 1);

    // 12th write of map 2 on the final-beat edge of map 1
    b0 = hs_cyc.size(); lc0 = last_cnt;
    k = 0;
    for (int i = 0; i < 37; i++) begin
      if (i != 12) begin
        send(16'h5000, k);
        k++;
      end else begin
        tick();
      end
    end
    wait_idle("t6_idle");
    chk("t6_beats", hs_cyc.size() - b0, 36);
    chk("t6_no_bubble", hs_cyc[b0 + 12] - hs_cyc[b0 + 11], 1);
    chk("t6_map2_first", elem(b0 + 12, 0), 16'h50C0);
    chk("t6_map3_first", elem(b0 + 24, 0), 16'h5180);
    chk("t6_lasts", last_cnt - lc0, 3);
    chk("t6_overflow", overflow, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pooled_map_buffer.md
Name: pooled_map_buffer

Overview:
- Sits directly downstream of the 2x2 pooling layer. It collects the pooled 12-element columns, which arrive one per valid pulse, into complete 12x12 feature maps.
- Maps are stored in a ping-pong (two-bank) buffer. Each completed map is replayed column by column to the next conv stage over a valid/ready stream.
- The pooling stage has no backpressure, so this block absorbs it. Overflow is flagged, never stalled.

Parameters:
- ROWS, 12, elements per column (pooled column height)
- COLS, 12, columns per feature map
- DATA_W, 16, element width (signed fixed-point, passed through untouched)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  one-cycle pulse; in_column is valid (driven by pooling valid_out)
- in_column  in  ROWS*DATA_W  packed [ROWS-1:0][DATA_W-1:0] pooled column, element 0 = top row
- out_valid  out  1  out_column holds a valid column
- out_ready  in  1  downstream accepts the column this cycle
- out_column  out  ROWS*DATA_W  replayed column
- out_col_idx  out  4  column index 0..COLS-1 of out_column
- out_last  out  1  high with the final column (idx COLS-1) of a map
- overflow  out  1  sticky; a column was dropped because both banks were busy
- busy  out  1  any bank filling or draining

Behaviour:
- Reset (rst low, async) forces:
  - out_valid=0, out_column=0, out_col_idx=0, out_last=0, overflow=0, busy=0
  - both banks EMPTY; write and read pointers = bank 0, column 0
- Storage: two banks of COLS x ROWS x DATA_W registers. Each bank has a state EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
- Write side:
  - On in_valid, in_column is written to wr_bank[wr_col]; that bank becomes FILLING.
  - wr_col increments. At wr_col==COLS-1 the write marks the bank FULL, wr_col wraps to 0 and wr_bank toggles.
- Write blocked:
  - If in_valid arrives while wr_bank is FULL or DRAINING, the column is dropped and overflow is set (sticky until reset).
  - wr_col is not advanced by a dropped column.
- Read side (FSM IDLE / STREAM):
  - IDLE: when rd_bank is FULL, move to STREAM next cycle. rd_bank becomes DRAINING; out_valid=1, out_column=rd_bank[0], out_col_idx=0. Latency from the last write to first out_valid = 1 cycle.
  - STREAM: out_valid stays high and out_column, out_col_idx and out_last hold stable until out_valid&&out_ready (AXI-style; no retraction).
  - On a handshake at idx<COLS-1, the next column is presented the next cycle; this gives 1 column/cycle with ready held high.
  - On a handshake with out_last: rd_bank becomes EMPTY and rd_bank toggles. If the other bank is already FULL, continue STREAM at idx 0 of that bank with no bubble; else go to IDLE with out_valid=0.
- Output registers: out_column, out_col_idx and out_last are registered from bank contents. out_last = (out_col_idx==COLS-1) while out_valid.
- Simultaneous events:
  - A write completing bank A in the same cycle as the last read of bank B: both state updates take effect. Bank B's freed EMPTY state is visible to writes from the next cycle.
  - A write into a bank in the same cycle that bank finishes draining is dropped (bank was DRAINING at the write edge).
- Partial maps: no timeout. A partially filled bank waits indefinitely. Reset is the only way to discard it.
- Reset mid-stream: all state is discarded immediately, out_valid drops asynchronously, and no partial map is replayed.
- busy = (any bank != EMPTY).

Decomposition:
- Shared package cnn_pkg:
  - DATA_W and POOL_ROWS/POOL_COLS (12) constants
  - typedef column_t = logic [ROWS-1:0][DATA_W-1:0]
  - typedef enum bank_state_t {EMPTY, FILLING, FULL, DRAINING}
- One natural sub-module: map_bank. It holds one COLS x column_t register array, a write port (we, wr_col, column) and a combinational read port (rd_col). It is instantiated twice.
- The control FSM and pointers stay in the top.

Test Plan:
- Single map: 12 in_valid pulses, column c holds element r = c*16+r, out_ready=1 → out_valid rises 1 cycle after the 12th write; 12 consecutive beats idx 0..11 with matching data; out_last only on idx 11; overflow=0.
- Backpressure: out_ready toggles 1,0,0,1… during drain → each column held stable while ready=0; every column appears exactly once in order; no beat lost or duplicated.
- Ping-pong, no bubble: 24 back-to-back in_valid pulses, out_ready=1 → second map's idx 0 is presented the cycle after the first map's out_last handshake; 24 output beats total.
- Overflow: out_ready=0, send 36 columns → first 24 stored; columns 25-36 dropped; overflow=1 from the 25th write. Then ready=1 → exactly 24 beats, data from the first two maps only.
- Async reset mid-stream: assert rst low during beat 5 of a drain (between clock edges) → out_valid=0 immediately, busy=0, overflow=0. A fresh 12-column map afterwards replays correctly from idx 0.
- Simultaneous fill/drain: time the 12th write of map 2 to coincide with the out_last handshake of map 1 → map 2 streams with no bubble; map 3's first column, arriving the following cycle, lands in the freed bank without overflow.
